query_rx: RTL and testbench
===========================

QUERY_RX -- requirements
Module: query_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: idle clocks between accepted bits before a frame aborts. Used only under QUERY_RX_TIMEOUT_EN.
REQ-002 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have: frame_start  in  1  one-cycle pulse; delimiter detected, new command begins.
REQ-005 SHALL have: bit_valid  in  1  one-cycle strobe; bit_in carries a decoded bit.
REQ-006 SHALL have: bit_in  in  1  decoded command bit, MSB-first.
REQ-007 SHALL have: frame_end  in  1  one-cycle pulse; command transmission ended.
REQ-008 SHALL have: busy  out  1  high in RECV or IGNORE.
REQ-009 SHALL have: q_valid, crc_err, len_err  out  1 each  one-cycle result pulses.
REQ-010 SHALL have: dr 1, m 2, trext 1, sel 2, session 2, target 1, q 4  out  decoded Query fields.

Function
REQ-011 SHALL run FSM states IDLE, RECV, IGNORE, CHECK.
REQ-012 Frame layout SHALL be cmd[4]=1000, DR, M[2], TRext, Sel[2], Session[2], Target, Q[4], CRC5[5], i.e. 22 bits.
REQ-013 frame_start SHALL, in any state, clear the bit counter, preset CRC to 5'b01001 and enter RECV. A bit_valid in the same cycle SHALL be discarded.
REQ-014 In RECV, each bit_valid SHALL shift bit_in into a 22-bit register, update CRC and increment a 5-bit counter that saturates at 31.
REQ-015 CRC SHALL use polynomial x^5+x^3+1: fb = bit ^ c[4]; c = {c[3:0],0} ^ (fb ? 5'b01001 : 0).
REQ-016 After the 4th bit, if cmd != 4'b1000, the FSM SHALL enter IGNORE and drop all bits until frame_start or frame_end. No result pulse SHALL be issued.
REQ-017 frame_end in RECV SHALL enter CHECK. A bit_valid in the same cycle SHALL be accepted before the end is evaluated.
REQ-018 CHECK SHALL last one cycle, then return to IDLE. Result pulses SHALL appear the cycle after frame_end.
REQ-019 In CHECK, if count != 22, only len_err SHALL pulse.
REQ-020 In CHECK, if count == 22 and the residue is 5'b00000, q_valid SHALL pulse and the field outputs SHALL load from the shift register.
REQ-021 In CHECK, if count == 22 and the residue is nonzero, only crc_err SHALL pulse.
REQ-022 At most one of q_valid, crc_err and len_err SHALL be high in any cycle.
REQ-023 Field outputs SHALL hold their last valid Query until the next q_valid; errors SHALL leave them unchanged.
REQ-024 frame_end in IDLE SHALL be ignored. frame_end in IGNORE SHALL return to IDLE.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, counter 0, CRC 5'b01001, all outputs 0.
REQ-026 Reset mid-frame SHALL discard the frame without any result pulse.

Configuration
REQ-027 With QUERY_RX_TIMEOUT_EN defined, an 8-bit idle counter SHALL run in RECV or IGNORE and clear on each bit_valid.
REQ-028 When that counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE. In RECV it SHALL also pulse len_err; in IGNORE it SHALL not.
REQ-029 Without QUERY_RX_TIMEOUT_EN, no idle counter SHALL exist and frames SHALL wait indefinitely.

Structure
REQ-030 A shared package SHALL hold QUERY_CMD (4'b1000), QUERY_LEN (22), CRC5_PRESET (5'b01001), CRC5_POLY (5'b01001) and the FSM state enum.
REQ-031 The CRC SHALL be a synchronous sub-module query_crc5 with ports clk, reset_n, init, en, bit_in and crc[4:0].

Verification
REQ-032 Bench SHALL send 22'h200010 (Query, all fields 0, CRC 10000), then frame_end. Required: q_valid one cycle later; all fields 0; busy low next cycle.
REQ-033 Bench SHALL send 22'h200010 with bit 4 of the frame value (CRC MSB, 18th bit sent) flipped. Required: crc_err pulse; fields unchanged from the previous run.
REQ-034 Bench SHALL send 21 valid bits, then frame_end. Required: len_err pulse and no q_valid.
REQ-035 Bench SHALL send cmd 4'b1001 followed by 18 bits and frame_end. Required: no result pulses; FSM back in IDLE.
REQ-036 Bench SHALL send frame_start after 10 bits, then a full 22'h200010. Required: single q_valid. Bench SHALL also assert reset_n low mid-frame. Required: outputs 0 and no pulse.
REQ-037 With QUERY_RX_TIMEOUT_EN and TIMEOUT_CYCLES=16, bench SHALL stall 16 cycles after 5 bits. Required: len_err pulse, then IDLE.

Source files
------------

// File: rtl/query_rx_pkg.sv
// Shared constants, FSM state encoding and field layout for the Query command receiver.
package query_rx_pkg;

  localparam logic [3:0] QUERY_CMD   = 4'b1000;
  localparam logic [4:0] QUERY_LEN   = 5'd22;
  localparam logic [4:0] CRC5_PRESET = 5'b01001;
  localparam logic [4:0] CRC5_POLY   = 5'b01001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_IGNORE,
    ST_CHECK
  } state_t;

  typedef struct packed {
    logic       dr;
    logic [1:0] m;
    logic       trext;
    logic [1:0] sel;
    logic [1:0] session;
    logic       target;
    logic [3:0] q;
  } query_fields_t;

endpackage

// File: rtl/query_crc5.sv
// Serial CRC-5 (x^5+x^3+1) over the received bit stream; init has priority over en.
module query_crc5
  import query_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init,
  input  logic       en,
  input  logic       bit_in,
  output logic [4:0] crc
);

  logic fb;

  always_comb begin
    fb = bit_in ^ crc[4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= CRC5_PRESET;
    end else if (init) begin
      crc <= CRC5_PRESET;
    end else if (en) begin
      crc <= {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    end
  end

endmodule

// File: rtl/query_rx.sv
// Query command receiver: collects a 22-bit frame, checks length and CRC-5, latches fields.
// Optional idle timeout enabled by defining QUERY_RX_TIMEOUT_EN.
module query_rx
  import query_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       frame_end,
  output logic       busy,
  output logic       q_valid,
  output logic       crc_err,
  output logic       len_err,
  output logic       dr,
  output logic [1:0] m,
  output logic       trext,
  output logic [1:0] sel,
  output logic [1:0] session,
  output logic       target,
  output logic [3:0] q
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("query_rx: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t        state, state_nx;
  logic [21:0]   sreg;
  logic [4:0]    cnt;
  logic [4:0]    crc;
  query_fields_t fields;
  logic          accept;
  logic [3:0]    cmd_nx;
  logic          bad_cmd;
  logic          len_ok;
  logic          frame_ok;
  logic          timeout;

  always_comb begin
    accept  = (state == ST_RECV) && bit_valid && !frame_start;
    cmd_nx  = {sreg[2:0], bit_in};
    bad_cmd = accept && (cnt == 5'd3) && (cmd_nx != QUERY_CMD);
    len_ok  = (cnt == QUERY_LEN);
    frame_ok = len_ok && (crc == 5'b00000) && (sreg[21:18] == QUERY_CMD);
  end

`ifdef QUERY_RX_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] idle_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (frame_start || bit_valid || !(state == ST_RECV || state == ST_IGNORE)) begin
      idle_cnt <= '0;
    end else if (idle_cnt != '1) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  always_comb begin
    timeout = (state == ST_RECV || state == ST_IGNORE) && (idle_cnt == TIMEOUT_LIM);
  end
`else
  always_comb begin
    timeout = 1'b0;
  end
`endif

  query_crc5 u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (frame_start),
    .en      (accept),
    .bit_in  (bit_in),
    .crc     (crc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (frame_start) begin
      state_nx = ST_RECV;
    end else if (timeout) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   state_nx = ST_IDLE;
        // A wrong opcode arriving together with frame_end has nothing left to drop.
        ST_RECV: begin
          if (bad_cmd)        state_nx = frame_end ? ST_IDLE : ST_IGNORE;
          else if (frame_end) state_nx = ST_CHECK;
        end
        ST_IGNORE: if (frame_end) state_nx = ST_IDLE;
        ST_CHECK:  state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state == ST_RECV) || (state == ST_IGNORE);
    q_valid = (state == ST_CHECK) && frame_ok;
    crc_err = (state == ST_CHECK) && len_ok && !frame_ok;
    len_err = ((state == ST_CHECK) && !len_ok) || ((state == ST_RECV) && timeout);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (frame_start) begin
      cnt <= '0;
    end else if (accept) begin
      sreg <= {sreg[20:0], bit_in};
      if (cnt != 5'd31) cnt <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fields <= '0;
    end else if (state == ST_CHECK && frame_ok) begin
      fields <= query_fields_t'(sreg[17:5]);
    end
  end

  always_comb begin
    dr      = fields.dr;
    m       = fields.m;
    trext   = fields.trext;
    sel     = fields.sel;
    session = fields.session;
    target  = fields.target;
    q       = fields.q;
  end

endmodule

// File: tb/tb_query_rx.sv
// Self-checking bench for query_rx: table of frames plus hand sequences, results via scoreboard.
// Timeout sequence selected by QUERY_RX_TIMEOUT_EN.
module tb_query_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       frame_end = 1'b0;
  logic       busy, q_valid, crc_err, len_err;
  logic       dr, trext, target;
  logic [1:0] m, sel, session;
  logic [3:0] q;

  always #5 clk = ~clk;

  query_rx #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .frame_end   (frame_end),
    .busy        (busy),
    .q_valid     (q_valid),
    .crc_err     (crc_err),
    .len_err     (len_err),
    .dr          (dr),
    .m           (m),
    .trext       (trext),
    .sel         (sel),
    .session     (session),
    .target      (target),
    .q           (q)
  );

  // res encodes the expected pulse as {q_valid, crc_err, len_err}
  typedef struct {
    logic [3:0]  cmd;
    logic [12:0] fields;
    logic [21:0] flip;
    int unsigned nbits;
    bit          end_last;
    logic [2:0]  res;
  } vec_t;

  typedef struct {
    logic [2:0]  res;
    logic [12:0] fields;
  } exp_t;

  localparam logic [2:0] R_QV = 3'b100, R_CRC = 3'b010, R_LEN = 3'b001, R_NONE = 3'b000;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pulse = 0;
  logic [12:0] last_fields = '0;
  vec_t        vecs[10];

  function automatic logic [4:0] crc5(input logic [16:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'b01001;
    for (int i = 16; i >= 0; i--) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b01001 : 5'b00000);
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic cyc(input logic fs, input logic bv, input logic bi, input logic fe);
    @(negedge clk);
    frame_start = fs;
    bit_valid   = bv;
    bit_in      = bi;
    frame_end   = fe;
  endtask

  function automatic logic [12:0] dut_fields();
    return {dr, m, trext, sel, session, target, q};
  endfunction

  initial begin : monitor
    exp_t e;
    exp_t pe;
    bit   pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("fields_after_result", dut_fields(), pe.fields);
        pend = 1'b0;
      end
      if (q_valid || crc_err || len_err) begin
        n_pulse++;
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {q_valid, crc_err, len_err}, R_NONE);
        end else begin
          e = sb.pop_front();
          chk("result_kind", {q_valid, crc_err, len_err}, e.res);
          pe   = e;
          pend = 1'b1;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input bit junk_with_start);
    logic [21:0] fr;
    exp_t        e;
    fr = {v.cmd, v.fields, crc5({v.cmd, v.fields})} ^ v.flip;
    if (v.res == R_QV) last_fields = v.fields;
    e.res    = v.res;
    e.fields = last_fields;
    if (v.res != R_NONE) sb.push_back(e);
    cyc(1'b1, junk_with_start, junk_with_start, 1'b0);
    for (int i = 0; i < int'(v.nbits); i++) begin
      logic b;
      b = (i < 22) ? fr[21 - i] : 1'b0;
      cyc(1'b0, 1'b1, b, v.end_last && (i == int'(v.nbits) - 1));
      if (i == 0) chk("busy_in_frame", busy, 1);
    end
    if (!(v.end_last && v.nbits > 0)) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pulse_latency", {q_valid, crc_err, len_err}, v.res);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("busy_after", busy, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic send_bits(input logic [21:0] fr, input int unsigned n);
    for (int i = 0; i < int'(n); i++) cyc(1'b0, 1'b1, fr[21 - i], 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin : main
    int p;
    int found;
    exp_t e;

    vecs[0] = '{4'b1000, 13'h0000, 22'h000000, 22, 1'b0, R_QV};
    vecs[1] = '{4'b1000, 13'h0000, 22'h000010, 22, 1'b0, R_CRC};
    vecs[2] = '{4'b1000, 13'h0000, 22'h000000, 21, 1'b0, R_LEN};
    vecs[3] = '{4'b1001, 13'h0000, 22'h000000, 22, 1'b0, R_NONE};
    vecs[4] = '{4'b1000, 13'h1FFF, 22'h000000, 22, 1'b0, R_QV};
    vecs[5] = '{4'b1000, 13'b1_01_0_10_01_1_0101, 22'h000000, 22, 1'b1, R_QV};
    vecs[6] = '{4'b1000, 13'h00F0, 22'h000100, 22, 1'b0, R_CRC};
    vecs[7] = '{4'b1000, 13'h0000, 22'h000000, 54, 1'b0, R_LEN};
    vecs[8] = '{4'b1000, 13'h0123, 22'h000000, 0, 1'b0, R_LEN};
    vecs[9] = '{4'b1000, 13'h00A5, 22'h000000, 23, 1'b0, R_LEN};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, q_valid, crc_err, len_err, dut_fields()}, 0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0);

    // restart after 10 bits of a frame
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(22'h200010, 10);
    run_vec(vecs[0], 1'b0);

    // restart from IGNORE
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(22'h3FFFFF, 6);
    chk("busy_in_ignore", busy, 1);
    run_vec(vecs[4], 1'b0);

    // bit_valid coinciding with frame_start must be discarded
    run_vec(vecs[5], 1'b1);

    // frame_end while idle
    p = n_pulse;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_frame_end_pulses", n_pulse - p, 0);
    chk("idle_frame_end_busy", busy, 0);

    // reset mid-frame
    run_vec(vecs[4], 1'b0);
    p = n_pulse;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(22'h200010, 8);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {busy, q_valid, crc_err, len_err, dut_fields()}, 0);
    last_fields = '0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midframe_reset_pulses", n_pulse - p, 0);
    chk("midframe_reset_fields", dut_fields(), 0);
    run_vec(vecs[1], 1'b0);

`ifdef QUERY_RX_TIMEOUT_EN
    e.res    = R_LEN;
    e.fields = last_fields;
    sb.push_back(e);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(22'h200010, 5);
    found = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (len_err) begin
        found = i;
        break;
      end
    end
    chk("timeout_recv_cycles", found, 17);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("timeout_recv_idle", busy, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("timeout_scoreboard", sb.size(), 0);

    p = n_pulse;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(22'h3FFFFF, 5);
    repeat (30) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("timeout_ignore_idle", busy, 0);
    chk("timeout_ignore_pulses", n_pulse - p, 0);
`else
    p = n_pulse;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(22'h200010, 5);
    repeat (40) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_still_busy", busy, 1);
    chk("stall_pulses", n_pulse - p, 0);
`endif
    run_vec(vecs[5], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
